// File: rtl/matmul_sequencer.sv
// matmul_sequencer: streams A (DM1) and B (DM3) words, accumulates byte dot products, writes C bytes to DM2.
// Build option MATMUL_SAT_EN: saturate results to 8'hFF and expose the sticky o_sat_flag output.
module matmul_sequencer #(
    parameter int          N         = 4,
    parameter logic [11:0] A_BASE    = 12'h000,
    parameter logic [11:0] B_BASE    = 12'h000,
    parameter logic [11:0] C_BASE    = 12'h000,
    parameter int          ACC_W     = 24,
    parameter int          OUT_SHIFT = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_we,
`ifdef MATMUL_SAT_EN
    output logic        o_sat_flag,
`endif
    input  logic [31:0] i_mem_rdata
);

    localparam int         KW       = N / 4;
    localparam int         CW       = 6;
    localparam logic [3:0] BANK_DM1 = 4'b0000;
    localparam logic [3:0] BANK_DM2 = 4'b0001;
    localparam logic [3:0] BANK_DM3 = 4'b0010;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_MAC  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    function automatic logic [ACC_W-1:0] dot4(input logic [31:0] a, input logic [31:0] b);
        logic [ACC_W-1:0] sum;
        logic [15:0]      prod;
        sum = {ACC_W{1'b0}};
        for (int lane = 0; lane < 4; lane++) begin
            prod = 16'(a[8*lane +: 8]) * 16'(b[8*lane +: 8]);
            sum  = sum + ACC_W'(prod);
        end
        return sum;
    endfunction

`ifdef MATMUL_SAT_EN
    function automatic logic clamps(input logic [ACC_W-1:0] acc);
        return ((acc >> OUT_SHIFT) > ACC_W'(9'd255));
    endfunction

    function automatic logic [7:0] narrow(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] sh;
        sh = acc >> OUT_SHIFT;
        if (clamps(acc)) begin
            return 8'hFF;
        end else begin
            return sh[7:0];
        end
    endfunction
`else
    function automatic logic [7:0] narrow(input logic [ACC_W-1:0] acc);
        return 8'(acc >> OUT_SHIFT);
    endfunction
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_i;
    logic [CW-1:0]    r_j;
    logic [CW-1:0]    r_k;
    logic [CW-1:0]    w_i_nxt;
    logic [CW-1:0]    w_j_nxt;
    logic [CW-1:0]    w_k_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [31:0]      r_a;
    logic [11:0]      w_addr_a;
    logic [11:0]      w_addr_b;
    logic [11:0]      w_addr_c;
    logic             r_busy;
    logic             r_done;
    logic             r_mem_we;
    logic [15:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;

    // State, loop counters, accumulator and the captured A word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_i     <= {CW{1'b0}};
            r_j     <= {CW{1'b0}};
            r_k     <= {CW{1'b0}};
            r_acc   <= {ACC_W{1'b0}};
            r_a     <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_acc   <= w_acc_nxt;
            if (r_state == S_RD_B) begin
                r_a <= i_mem_rdata;
            end
        end
    end

    // Next-state, counter stepping and accumulation.
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_acc_nxt   = r_acc;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RD_A;
                    w_i_nxt     = {CW{1'b0}};
                    w_j_nxt     = {CW{1'b0}};
                    w_k_nxt     = {CW{1'b0}};
                    w_acc_nxt   = {ACC_W{1'b0}};
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_A: w_state_nxt = S_RD_B;
            S_RD_B: w_state_nxt = S_MAC;
            S_MAC: begin
                // mem_rdata carries the B word here, r_a the matching A word
                w_acc_nxt = r_acc + dot4(r_a, i_mem_rdata);
                if (r_k == CW'(KW - 1)) begin
                    w_state_nxt = S_WR;
                end else begin
                    w_k_nxt     = r_k + CW'(1);
                    w_state_nxt = S_RD_A;
                end
            end
            S_WR: begin
                w_k_nxt   = {CW{1'b0}};
                w_acc_nxt = {ACC_W{1'b0}};
                if (r_j < CW'(N - 1)) begin
                    w_j_nxt     = r_j + CW'(1);
                    w_state_nxt = S_RD_A;
                end else if (r_i < CW'(N - 1)) begin
                    w_j_nxt     = {CW{1'b0}};
                    w_i_nxt     = r_i + CW'(1);
                    w_state_nxt = S_RD_A;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    assign w_addr_a = A_BASE + 12'(w_i_nxt) * 12'(KW) + 12'(w_k_nxt);
    assign w_addr_b = B_BASE + 12'(w_j_nxt) * 12'(KW) + 12'(w_k_nxt);
    assign w_addr_c = C_BASE + 12'(w_i_nxt) * 12'(N) + 12'(w_j_nxt);

    // Registered bus and status outputs; address and data hold outside the access states.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 32'h0000_0000;
        end else begin
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= (w_state_nxt == S_DONE);
            r_mem_we <= (w_state_nxt == S_WR);
            case (w_state_nxt)
                S_RD_A: r_mem_addr <= {BANK_DM1, w_addr_a};
                S_RD_B: r_mem_addr <= {BANK_DM3, w_addr_b};
                S_WR: begin
                    r_mem_addr  <= {BANK_DM2, w_addr_c};
                    r_mem_wdata <= {24'h00_0000, narrow(w_acc_nxt)};
                end
                default: begin
                    r_mem_addr  <= r_mem_addr;
                    r_mem_wdata <= r_mem_wdata;
                end
            endcase
        end
    end

`ifdef MATMUL_SAT_EN
    logic r_sat_flag;

    // Sticky clamp indicator, cleared when a job is accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sat_flag <= 1'b0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_sat_flag <= 1'b0;
        end else if ((r_state == S_MAC) && (w_state_nxt == S_WR) && clamps(w_acc_nxt)) begin
            r_sat_flag <= 1'b1;
        end
    end

    assign o_sat_flag = r_sat_flag;
`endif

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: two instances (N=4 and N=8) with bank memories, an element-level
// matrix-product reference model, and a cycle timeline derived from the element schedule.
module tb_matmul_sequencer;

    localparam int AB8 = 4090;   // 12'hFFA, A words wrap the 4K space
    localparam int BB8 = 64;
    localparam int CB8 = 4064;   // 12'hFE0, C bytes wrap the 4K space

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, rst8, st4, st8;
    logic        busy4, done4, we4, busy8, done8, we8;
    logic [15:0] addr4, addr8;
    logic [31:0] wd4, wd8;
    logic [31:0] q4 = 32'h0;
    logic [31:0] q8 = 32'h0;
`ifdef MATMUL_SAT_EN
    logic        sat4, sat8;
`endif
    logic [31:0] dm1_4 [4096];
    logic [31:0] dm3_4 [4096];
    logic [31:0] dm1_8 [4096];
    logic [31:0] dm3_8 [4096];

    int   n_cmp = 0;
    int   n_bad = 0;
    logic sel = 1'b0;
    int   ma [32][32];
    int   mb [32][32];
    int   c_exp [32][32];
    int   c_got [4096];
    logic sat_exp;

    matmul_sequencer #(.N(4), .A_BASE(12'h000), .B_BASE(12'h000), .C_BASE(12'h000),
                       .ACC_W(24), .OUT_SHIFT(0)) dut4 (
        .i_clk(clk), .i_rst(rst4), .i_start(st4), .o_busy(busy4), .o_done(done4),
        .o_mem_addr(addr4), .o_mem_wdata(wd4), .o_mem_we(we4),
`ifdef MATMUL_SAT_EN
        .o_sat_flag(sat4),
`endif
        .i_mem_rdata(q4));

    matmul_sequencer #(.N(8), .A_BASE(12'hFFA), .B_BASE(12'h040), .C_BASE(12'hFE0),
                       .ACC_W(24), .OUT_SHIFT(4)) dut8 (
        .i_clk(clk), .i_rst(rst8), .i_start(st8), .o_busy(busy8), .o_done(done8),
        .o_mem_addr(addr8), .o_mem_wdata(wd8), .o_mem_we(we8),
`ifdef MATMUL_SAT_EN
        .o_sat_flag(sat8),
`endif
        .i_mem_rdata(q8));

    // Memory controller model: Q shows the addressed word one cycle later
    always @(posedge clk) begin
        case (addr4[15:12])
            4'h0:    q4 <= dm1_4[addr4[11:0]];
            4'h2:    q4 <= dm3_4[addr4[11:0]];
            default: q4 <= 32'h0;
        endcase
        case (addr8[15:12])
            4'h0:    q8 <= dm1_8[addr8[11:0]];
            4'h2:    q8 <= dm3_8[addr8[11:0]];
            default: q8 <= 32'h0;
        endcase
    end

    logic        m_busy, m_done, m_we;
    logic [15:0] m_addr;
    logic [31:0] m_wdata;
    assign m_busy  = sel ? busy8 : busy4;
    assign m_done  = sel ? done8 : done4;
    assign m_we    = sel ? we8   : we4;
    assign m_addr  = sel ? addr8 : addr4;
    assign m_wdata = sel ? wd8   : wd4;
`ifdef MATMUL_SAT_EN
    logic m_sat;
    assign m_sat = sel ? sat8 : sat4;
`endif

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) st8 = v; else st4 = v;
    endtask

    task automatic set_rst(input logic v);
        if (sel) rst8 = v; else rst4 = v;
    endtask

    task automatic fill(input int n, input int mode);
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                case (mode)
                    0:       begin ma[r][c] = (r == c) ? 1 : 0; mb[r][c] = r * n + c + 1; end
                    1:       begin ma[r][c] = 255; mb[r][c] = 255; end
                    2:       begin ma[r][c] = 2; mb[r][c] = 2; end
                    default: begin ma[r][c] = int'($urandom_range(0, 255)); mb[r][c] = int'($urandom_range(0, 255)); end
                endcase
            end
        end
    endtask

    // Pack A/B into the selected instance's banks and compute the expected C.
    task automatic load_job(input int n, input int ab, input int bb, input int shift);
        int          kw;
        logic [31:0] w;
        longint      acc, sh;
        kw      = n / 4;
        sat_exp = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < kw; k++) begin
                for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'(ma[i][4*k+b]);
                if (sel) dm1_8[(ab + i*kw + k) % 4096] = w; else dm1_4[(ab + i*kw + k) % 4096] = w;
                for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'(mb[4*k+b][i]);
                if (sel) dm3_8[(bb + i*kw + k) % 4096] = w; else dm3_4[(bb + i*kw + k) % 4096] = w;
            end
        end
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                acc = 0;
                for (int k = 0; k < n; k++) acc += longint'(ma[i][k]) * longint'(mb[k][j]);
                sh = acc >>> shift;
`ifdef MATMUL_SAT_EN
                if (sh > 255) begin c_exp[i][j] = 255; sat_exp = 1'b1; end
                else c_exp[i][j] = int'(sh);
`else
                c_exp[i][j] = int'(sh % 256);
`endif
            end
        end
    endtask

    // One job: start at edge 0, optional extra start pulse / reset at given cycles, then check.
    task automatic run_job(input int n, input int ab, input int bb, input int cb,
                           input int busy_cyc, input int rst_cyc);
        int          kw, per, total, c_end, e, p, ii, jj;
        int          writes, bus_err, first_w, done_cyc, exp_wr, a;
        logic        x_busy, x_done, x_we;
        logic [15:0] x_addr, last_w;
        kw = n / 4; per = 3 * kw + 1; total = 1 + n * n * per;
        last_w = {4'h1, 12'(cb + n*n - 1)};
        writes = 0; bus_err = 0; first_w = -1; done_cyc = -1;
        for (int x = 0; x < 4096; x++) c_got[x] = -1;
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        c_end = (rst_cyc > 0) ? rst_cyc + 3 : total + 2;
        for (int cyc = 1; cyc <= c_end; cyc++) begin
            @(negedge clk);
            if (rst_cyc > 0 && cyc > rst_cyc) begin
                x_busy = 1'b0; x_done = 1'b0; x_we = 1'b0; x_addr = 16'h0000;
            end else if (cyc < total) begin
                e = (cyc - 1) / per; p = (cyc - 1) % per; ii = e / n; jj = e % n;
                x_busy = 1'b1; x_done = 1'b0; x_we = 1'b0;
                if (p == per - 1) begin
                    x_we = 1'b1; x_addr = {4'h1, 12'(cb + ii*n + jj)};
                end else if (p % 3 == 0) begin
                    x_addr = {4'h0, 12'(ab + ii*kw + p/3)};
                end else begin
                    x_addr = {4'h2, 12'(bb + jj*kw + p/3)};
                end
            end else if (cyc == total) begin
                x_busy = 1'b1; x_done = 1'b1; x_we = 1'b0; x_addr = last_w;
            end else begin
                x_busy = 1'b0; x_done = 1'b0; x_we = 1'b0; x_addr = last_w;
            end
            if (m_busy !== x_busy || m_done !== x_done || m_we !== x_we || m_addr !== x_addr) begin
                bus_err++;
                if (bus_err == 1)
                    $display("first bus deviation at cycle %0d: busy %b done %b we %b addr %h, model %b %b %b %h",
                             cyc, m_busy, m_done, m_we, m_addr, x_busy, x_done, x_we, x_addr);
            end
            if (m_we === 1'b1) begin
                writes++;
                if (first_w < 0) first_w = int'(m_addr);
                if (m_wdata[31:8] !== 24'h0) bus_err++;
                if (m_addr[15:12] == 4'h1) c_got[m_addr[11:0]] = int'(m_wdata[7:0]);
                else bus_err++;
            end
            if (m_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (cyc == 1) set_start(1'b0);
            if (cyc == busy_cyc) set_start(1'b1);
            if (cyc == busy_cyc + 1) set_start(1'b0);
            if (cyc == rst_cyc) set_rst(1'b1);
            if (cyc == rst_cyc + 1) set_rst(1'b0);
        end
        exp_wr = (rst_cyc > 0 && rst_cyc < total) ? rst_cyc / per : n * n;
        chk("bus_protocol", bus_err, 0);
        chk("done_cycle", done_cyc, (rst_cyc > 0) ? -1 : total);
        chk("write_count", writes, exp_wr);
        chk("first_write_addr", first_w, (1 << 12) | cb);
        for (int x = 0; x < n * n; x++) begin
            ii = x / n; jj = x % n; a = (cb + ii*n + jj) % 4096;
            chk($sformatf("c[%0d][%0d]", ii, jj), c_got[a], (x < exp_wr) ? c_exp[ii][jj] : -1);
        end
`ifdef MATMUL_SAT_EN
        if (rst_cyc <= 0) chk("sat_flag", m_sat, sat_exp);
`endif
    endtask

    initial begin
        st4 = 1'b0; st8 = 1'b0; rst4 = 1'b1; rst8 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_we", we4, 0);
        chk("rst_addr", addr4, 0);
        chk("rst_wdata", wd4, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_addr8", addr8, 0);
        rst4 = 1'b0; rst8 = 1'b0;

        sel = 1'b0;
        fill(4, 0); load_job(4, 0, 0, 0); run_job(4, 0, 0, 0, -1, -1);
        chk("identity_c23", c_got[11], 12);
        fill(4, 1); load_job(4, 0, 0, 0); run_job(4, 0, 0, 0, -1, -1);
        for (int t = 0; t < 3; t++) begin
            fill(4, 3); load_job(4, 0, 0, 0);
            run_job(4, 0, 0, 0, (t == 1) ? 10 : -1, -1);
        end
        fill(4, 3); load_job(4, 0, 0, 0); run_job(4, 0, 0, 0, -1, 30);
        fill(4, 3); load_job(4, 0, 0, 0); run_job(4, 0, 0, 0, -1, -1);

        sel = 1'b1;
        fill(8, 2); load_job(8, AB8, BB8, 4); run_job(8, AB8, BB8, CB8, -1, -1);
        fill(8, 3); load_job(8, AB8, BB8, 4); run_job(8, AB8, BB8, CB8, 20, -1);
        fill(8, 3); load_job(8, AB8, BB8, 4); run_job(8, AB8, BB8, CB8, -1, 100);
        fill(8, 3); load_job(8, AB8, BB8, 4); run_job(8, AB8, BB8, CB8, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
